ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: 32 shift-add or restoring-subtract steps, then sign fix-up.
// Result lands in HI/LO 34 edges after start; stall_D holds back HI/LO readers while an operation is in flight.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [1:0]  op_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        abort_E,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wd,
    input  logic        hilo_use_D,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        stall_D
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [31:0] b_q, b_d;
    logic [63:0] p_q, p_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    // op bit 0 clear means a signed operation; bit 1 set means divide
    logic        start_signed;
    logic [31:0] a_mag, b_mag;
    assign start_signed = ~op_E[0];
    assign a_mag = (start_signed && A_E[31]) ? (32'd0 - A_E) : A_E;
    assign b_mag = (start_signed && B_E[31]) ? (32'd0 - B_E) : B_E;

    // Multiply step: p = {partial product, remaining multiplier bits}
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next = {mul_sum, p_q[31:1]};

    // Divide step: p = {partial remainder, dividend bits shifting into quotient}
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_next;
    assign div_shift = {p_q[63:32], p_q[31]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_sub   = div_shift[31:0] - b_q;
    assign div_next  = div_ge ? {div_sub, p_q[30:0], 1'b1}
                              : {div_shift[31:0], p_q[30:0], 1'b0};

    // Sign correction applied on the way out of FIX
    logic        fix_signed, fix_neg;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign fix_signed = ~op_q[0];
    assign fix_neg    = fix_signed & (sa_q ^ sb_q);
    assign prod_fix   = fix_neg ? (64'd0 - p_q) : p_q;
    assign quo_fix    = fix_neg ? (32'd0 - p_q[31:0]) : p_q[31:0];
    assign rem_fix    = (fix_signed && sa_q) ? (32'd0 - p_q[63:32]) : p_q[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        b_d     = b_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wd;
                if (wr_lo) lo_d = wd;
                if (start_E && !abort_E) begin
                    state_d = S_RUN;
                    cnt_d   = 5'd0;
                    op_d    = op_E;
                    sa_d    = start_signed & A_E[31];
                    sb_d    = start_signed & B_E[31];
                    b_d     = b_mag;
                    p_d     = {32'd0, a_mag};
                end
            end
            S_RUN: begin
                if (abort_E) begin
                    state_d = S_IDLE;
                end else begin
                    p_d   = op_q[1] ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (abort_E) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (op_q[1]) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            S_DONE: begin
                if (wr_hi) hi_d = wd;
                if (wr_lo) lo_d = wd;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            b_q     <= 32'd0;
            p_q     <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            b_q     <= b_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI      = hi_q;
    assign LO      = lo_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign stall_D = hilo_use_D && ((state_q == S_RUN) || (state_q == S_FIX));

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: each scenario task drives vectors and checks hand-computed HI/LO/timing.
module tb_ex_muldiv;

    logic        clk, reset, start_E, abort_E, wr_hi, wr_lo, hilo_use_D;
    logic [1:0]  op_E;
    logic [31:0] A_E, B_E, wd;
    logic [31:0] HI, LO;
    logic        busy, done, stall_D;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    ex_muldiv dut (
        .clk(clk), .reset(reset), .start_E(start_E), .op_E(op_E), .A_E(A_E), .B_E(B_E),
        .abort_E(abort_E), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd), .hilo_use_D(hilo_use_D),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .stall_D(stall_D)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called just after a negedge; returns cycles from start to done plus HI/LO seen during done,
    // and leaves the bench at the negedge after done (DUT back in IDLE).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] hi, output logic [31:0] lo);
        start_E = 1'b1; op_E = op; A_E = a; B_E = b;
        @(negedge clk);
        start_E = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        hi = HI;
        lo = LO;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; start_E = 1'b0; abort_E = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        hilo_use_D = 1'b1; op_E = 2'b00; A_E = 32'd0; B_E = 32'd0; wd = 32'd0;
        #2;
        total++;
        if ({HI, LO} !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || stall_D !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: HI=%h LO=%h busy=%b done=%b stall=%b, want all 0", HI, LO, busy, done, stall_D);
        end
        @(negedge clk);
        reset = 1'b0;
        hilo_use_D = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu;
        int cyc; logic [31:0] hi, lo;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, hi, lo);
        total++;
        if (cyc !== 34) begin
            bad++;
            $display("FAIL multu_latency: got %0d cycles, want 34", cyc);
        end
        total++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++;
            $display("FAIL multu_max: got %h_%h, want fffffffe_00000001", hi, lo);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle: busy=%b done=%b after done, want 0 0", busy, done);
        end
    endtask

    task automatic test_mult;
        int cyc; logic [31:0] hi, lo;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, cyc, hi, lo);
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            bad++;
            $display("FAIL mult_neg: got %h_%h, want ffffffff_fffffff1", hi, lo);
        end
        run_op(OP_MULT, 32'hFFFFFFF9, 32'hFFFFFFFA, cyc, hi, lo);
        total++;
        if (hi !== 32'h00000000 || lo !== 32'h0000002A) begin
            bad++;
            $display("FAIL mult_negneg: got %h_%h, want 00000000_0000002a", hi, lo);
        end
    endtask

    task automatic test_div;
        int cyc; logic [31:0] hi, lo;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, cyc, hi, lo);
        total++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL div_neg_a: got LO=%h HI=%h, want fffffffd ffffffff", lo, hi);
        end
        run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, cyc, hi, lo);
        total++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
            bad++;
            $display("FAIL div_neg_b: got LO=%h HI=%h, want fffffffd 00000001", lo, hi);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, cyc, hi, lo);
        total++;
        if (lo !== 32'h0000000E || hi !== 32'h00000002) begin
            bad++;
            $display("FAIL divu_basic: got LO=%h HI=%h, want 0000000e 00000002", lo, hi);
        end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, hi, lo);
        total++;
        if (lo !== 32'h80000000 || hi !== 32'h00000000) begin
            bad++;
            $display("FAIL div_overflow: got LO=%h HI=%h, want 80000000 00000000", lo, hi);
        end
    endtask

    task automatic test_div_zero;
        int cyc; logic [31:0] hi, lo;
        run_op(OP_DIV, 32'hFFFFFFF0, 32'h00000000, cyc, hi, lo);
        total++;
        if (lo !== 32'h00000001 || hi !== 32'hFFFFFFF0) begin
            bad++;
            $display("FAIL div_zero_neg: got LO=%h HI=%h, want 00000001 fffffff0", lo, hi);
        end
        run_op(OP_DIV, 32'h00000009, 32'h00000000, cyc, hi, lo);
        total++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'h00000009) begin
            bad++;
            $display("FAIL div_zero_pos: got LO=%h HI=%h, want ffffffff 00000009", lo, hi);
        end
        run_op(OP_DIVU, 32'h00000005, 32'h00000000, cyc, hi, lo);
        total++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'h00000005) begin
            bad++;
            $display("FAIL divu_zero: got LO=%h HI=%h, want ffffffff 00000005", lo, hi);
        end
    endtask

    task automatic test_stall;
        int cyc, n;
        hilo_use_D = 1'b1;
        start_E = 1'b1; op_E = OP_MULTU; A_E = 32'd6; B_E = 32'd7;
        @(negedge clk);
        start_E = 1'b0;
        cyc = 1; n = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (stall_D === 1'b1) n++;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL stall_cycles: got %0d, want 33", n);
        end
        total++;
        if (done !== 1'b1 || stall_D !== 1'b0) begin
            bad++;
            $display("FAIL stall_in_done: done=%b stall=%b, want 1 0", done, stall_D);
        end
        total++;
        if (LO !== 32'd42 || HI !== 32'd0) begin
            bad++;
            $display("FAIL stall_result: got %h_%h, want 00000000_0000002a", HI, LO);
        end
        @(negedge clk);
        hilo_use_D = 1'b0;
    endtask

    task automatic test_mt_write;
        wr_lo = 1'b1; wd = 32'h12345678;
        @(negedge clk);
        wr_lo = 1'b0;
        total++;
        if (LO !== 32'h12345678) begin
            bad++;
            $display("FAIL mtlo_idle: got %h, want 12345678", LO);
        end
        wr_hi = 1'b1; wd = 32'hA5A5A5A5;
        @(negedge clk);
        wr_hi = 1'b0;
        total++;
        if (HI !== 32'hA5A5A5A5 || LO !== 32'h12345678) begin
            bad++;
            $display("FAIL mthi_idle: got HI=%h LO=%h, want a5a5a5a5 12345678", HI, LO);
        end
    endtask

    task automatic test_abort;
        int seen;
        // abort beats a simultaneous start in IDLE
        start_E = 1'b1; abort_E = 1'b1; op_E = OP_MULTU; A_E = 32'd2; B_E = 32'd2;
        @(negedge clk);
        start_E = 1'b0; abort_E = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_vs_start: busy=%b, want 0", busy);
        end
        start_E = 1'b1;
        @(negedge clk);
        start_E = 1'b0;
        repeat (9) @(negedge clk);
        abort_E = 1'b1;
        @(negedge clk);
        abort_E = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy: busy=%b one cycle after abort, want 0", busy);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen !== 0 || HI !== 32'hA5A5A5A5 || LO !== 32'h12345678) begin
            bad++;
            $display("FAIL abort_no_result: done_seen=%0d HI=%h LO=%h, want 0 a5a5a5a5 12345678", seen, HI, LO);
        end
    endtask

    task automatic test_busy_ignores;
        int cyc;
        start_E = 1'b1; op_E = OP_DIVU; A_E = 32'd100; B_E = 32'd7;
        @(negedge clk);
        start_E = 1'b0;
        cyc = 1;
        repeat (5) begin @(negedge clk); cyc++; end
        start_E = 1'b1; op_E = OP_MULTU; A_E = 32'd3; B_E = 32'd3;
        wr_hi = 1'b1; wd = 32'hDEADBEEF;
        @(negedge clk);
        cyc++;
        start_E = 1'b0; wr_hi = 1'b0;
        total++;
        if (HI !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL mthi_busy: got HI=%h during RUN, want a5a5a5a5", HI);
        end
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 34 || LO !== 32'h0000000E || HI !== 32'h00000002) begin
            bad++;
            $display("FAIL start_ignored: cyc=%0d LO=%h HI=%h, want 34 0000000e 00000002", cyc, LO, HI);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        int cyc; logic [31:0] hi, lo;
        hilo_use_D = 1'b1;
        start_E = 1'b1; op_E = OP_MULTU; A_E = 32'hFFFF; B_E = 32'hFFFF;
        @(negedge clk);
        start_E = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({HI, LO} !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || stall_D !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun: HI=%h LO=%h busy=%b done=%b stall=%b, want all 0", HI, LO, busy, done, stall_D);
        end
        @(negedge clk);
        reset = 1'b0;
        hilo_use_D = 1'b0;
        run_op(OP_DIVU, 32'd100, 32'd7, cyc, hi, lo);
        total++;
        if (cyc !== 34 || lo !== 32'h0000000E || hi !== 32'h00000002) begin
            bad++;
            $display("FAIL start_after_reset: cyc=%0d LO=%h HI=%h, want 34 0000000e 00000002", cyc, lo, hi);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_mt_write();
        test_abort();
        test_busy_ignores();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
